// File: rtl/ram_dp_clr.sv
// True dual-port RAM with byte-lane write enables and a one-word-per-cycle clear engine.
// Reset (and clear_req) fill every word with clear_value_g; ports are locked out while busy.
//
// state | meaning
// IDLE  | ports serviced normally
// CLEAR | clear_value_g written at cnt_q each cycle, port accesses rejected
module ram_dp_clr #(
    parameter int unsigned                addr_width_g  = 11,
    parameter int unsigned                data_width_g  = 8,
    parameter bit                         rdw_new_g     = 1'b1,
    parameter logic [data_width_g-1:0]    clear_value_g = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable_a,
    input  logic                          enable_b,
    input  logic                          wren_a,
    input  logic                          wren_b,
    input  logic [data_width_g/8-1:0]     be_a,
    input  logic [data_width_g/8-1:0]     be_b,
    input  logic [addr_width_g-1:0]       address_a,
    input  logic [addr_width_g-1:0]       address_b,
    input  logic [data_width_g-1:0]       data_a,
    input  logic [data_width_g-1:0]       data_b,
    output logic [data_width_g-1:0]       q_a,
    output logic [data_width_g-1:0]       q_b,
    output logic                          valid_a,
    output logic                          valid_b,
    input  logic                          clear_req,
    output logic                          busy
);

    localparam int lanes_c = data_width_g / 8;
    localparam int depth_c = 2 ** addr_width_g;
    localparam logic [addr_width_g-1:0] addr_max_c = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [addr_width_g-1:0]   cnt_q, cnt_d;
    logic [data_width_g-1:0]   q_a_q, q_a_d, q_b_q, q_b_d;
    logic                      valid_a_q, valid_a_d, valid_b_q, valid_b_d;

    logic [data_width_g-1:0]   mem [depth_c];

    logic                      acc_a, acc_b;
    logic                      wr_a, wr_b;
    logic                      wr_a_any, wr_b_any;
    logic                      same_addr;
    logic [data_width_g-1:0]   rd_a, rd_b;
    logic [data_width_g-1:0]   word_new_a, word_new_b;

    assign busy      = (state_q == CLEAR);
    assign acc_a     = enable_a & ~busy;
    assign acc_b     = enable_b & ~busy;
    assign wr_a      = acc_a & wren_a;
    assign wr_b      = acc_b & wren_b;
    assign wr_a_any  = wr_a & (|be_a);
    assign wr_b_any  = wr_b & (|be_b);
    assign same_addr = (address_a == address_b);
    assign rd_a      = mem[address_a];
    assign rd_b      = mem[address_b];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == addr_max_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Post-write word at each port's address; port A wins lanes both ports enable.
    always_comb begin
        word_new_a = rd_a;
        word_new_b = rd_b;
        for (int i = 0; i < lanes_c; i++) begin
            if (wr_b && same_addr && be_b[i]) word_new_a[8*i +: 8] = data_b[8*i +: 8];
            if (wr_a && be_a[i])              word_new_a[8*i +: 8] = data_a[8*i +: 8];
            if (wr_b && be_b[i])              word_new_b[8*i +: 8] = data_b[8*i +: 8];
            if (wr_a && same_addr && be_a[i]) word_new_b[8*i +: 8] = data_a[8*i +: 8];
        end
    end

    // A reader that is not itself writing always sees the pre-write word.
    always_comb begin
        q_a_d     = q_a_q;
        q_b_d     = q_b_q;
        valid_a_d = 1'b0;
        valid_b_d = 1'b0;
        if (acc_a) begin
            valid_a_d = 1'b1;
            q_a_d     = (rdw_new_g && wr_a_any) ? word_new_a : rd_a;
        end
        if (acc_b) begin
            valid_b_d = 1'b1;
            q_b_d     = (rdw_new_g && wr_b_any) ? word_new_b : rd_b;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            q_a_q     <= '0;
            q_b_q     <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            q_a_q     <= q_a_d;
            q_b_q     <= q_b_d;
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (busy) begin
                mem[cnt_q] <= clear_value_g;
            end else begin
                for (int i = 0; i < lanes_c; i++) begin
                    if (wr_a && be_a[i]) begin
                        mem[address_a][8*i +: 8] <= data_a[8*i +: 8];
                    end
                    if (wr_b && be_b[i] && !(same_addr && wr_a && be_a[i])) begin
                        mem[address_b][8*i +: 8] <= data_b[8*i +: 8];
                    end
                end
            end
        end
    end

    assign q_a     = q_a_q;
    assign q_b     = q_b_q;
    assign valid_a = valid_a_q;
    assign valid_b = valid_b_q;

endmodule

// File: doc/ram_dp_clr.md
RAM_DP_CLR -- requirements
Module: ram_dp_clr

Interface
REQ-001 SHALL have parameter addr_width_g, default 11, meaning address bits; depth = 2**addr_width_g words.
REQ-002 SHALL have parameter data_width_g, default 8, meaning word width; must be a multiple of 8; lanes = data_width_g/8.
REQ-003 SHALL have parameter rdw_new_g, default 1, meaning read-during-write result: 1 = new data, 0 = old data.
REQ-004 SHALL have parameter clear_value_g, default 0, meaning the word written to every address during a clear.
REQ-005 SHALL have port clock, input, 1, meaning the single clock; all logic is on the rising edge.
REQ-006 SHALL have port reset, input, 1, meaning a synchronous, active-high reset.
REQ-007 SHALL have ports enable_a/enable_b, input, 1, meaning the port access is enabled.
REQ-008 SHALL have ports wren_a/wren_b, input, 1, meaning write when enabled.
REQ-009 SHALL have ports be_a/be_b, input, lanes, meaning byte-lane write enables; bit i covers data bits 8i+7:8i.
REQ-010 SHALL have ports address_a/address_b, input, addr_width_g, meaning the word address.
REQ-011 SHALL have ports data_a/data_b, input, data_width_g, meaning write data.
REQ-012 SHALL have ports q_a/q_b, output, data_width_g, meaning registered read data.
REQ-013 SHALL have ports valid_a/valid_b, output, 1, meaning q_x was updated by an accepted access in the previous cycle.
REQ-014 SHALL have port clear_req, input, 1, meaning a request to fill the whole memory with clear_value_g.
REQ-015 SHALL have port busy, output, 1, meaning a clear is in progress and port accesses are rejected.

Function
REQ-016 SHALL implement the FSM states IDLE and CLEAR; busy = (state == CLEAR).
REQ-017 SHALL transition IDLE->CLEAR on clear_req, with busy high from the next cycle.
REQ-018 SHALL, in CLEAR, write clear_value_g to the address held in an addr_width_g-bit counter starting at 0, one word per cycle, ignoring be_x.
REQ-019 SHALL, in CLEAR with counter at addr_max, write that word and return to IDLE next cycle, so busy is high for exactly 2**addr_width_g cycles.
REQ-020 SHALL ignore clear_req while in CLEAR: no restart and no queuing.
REQ-021 SHALL, while busy, drop all port writes and reads, hold q_x unchanged, and set valid_x to 0.
REQ-022 SHALL accept a port access when enable_x & ~busy; on the next cycle valid_x = 1 (read latency 1); otherwise valid_x = 0.
REQ-023 SHALL, on an accepted write, update only the lanes with be_x[i]=1; be_x = 0 with wren_x makes the access behave as a read.
REQ-024 SHALL, on an accepted same-port write with rdw_new_g=1, load q_x with the word as stored after the write; with rdw_new_g=0, load it with the pre-write contents.
REQ-025 SHALL, on a cross-port collision (one port writes address X while the other reads X in the same cycle), give the reader the pre-write contents regardless of rdw_new_g.
REQ-026 SHALL, when both ports write the same address in the same cycle, take port A's data in lanes both ports enable and each port's own data in lanes only it enables; under rdw_new_g=1 both q_a and q_b show the resulting stored word.
REQ-027 SHALL treat distinct-address simultaneous accesses as fully independent.

Reset
REQ-028 SHALL, on reset, set q_a = q_b = 0, valid_a = valid_b = 0, counter = 0, and state = CLEAR, so memory is cleared after every reset (busy = 1 the cycle after reset is asserted).
REQ-029 SHALL, on reset asserted mid-clear, restart the clear from address 0; while reset is held, no memory writes occur and busy stays 1.
REQ-030 SHALL ensure memory contents are defined only after the first post-reset clear completes.

Verification
REQ-031 SHALL cover post-reset clear: addr_width_g=4, release reset -> busy high for exactly 16 cycles; then a read of every address -> q = clear_value_g, valid = 1 one cycle after the read.
REQ-032 SHALL cover byte enables: data_width_g=16, write 0xABCD at address 3 with be=11, then be=01 with 0x1234 -> read returns 0xAB34.
REQ-033 SHALL cover read-during-write: address 5 holds 0x11, port A writes 0x22 -> q_a = 0x22 (rdw_new_g=1) or 0x11 (rdw_new_g=0); port B reading address 5 in the same cycle gets 0x11.
REQ-034 SHALL cover a write collision: A writes 0xAA00 with be=10 and B writes 0x55BB with be=11 to the same address -> stored 0xAABB.
REQ-035 SHALL cover busy rejection: clear_req, then a write of 0x77 to address 2 on the next cycle -> valid = 0, write dropped, and address 2 reads clear_value_g after the clear completes.
REQ-036 SHALL cover reset mid-clear: reset at counter = 7 -> the clear restarts at 0 and busy lasts a full 2**addr_width_g cycles after reset release.
